// File: rtl/hamming_pkg.sv
// Shared Hamming(8,4) SECDED definitions: codeword layout, status codes and helpers.
// Used by both the encoder and the decoder so the bit map lives in one place.
package hamming_pkg;

  localparam int CODE_W = 8;
  localparam int DATA_W = 4;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P3_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;
  localparam int P4_IDX = 7;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    CORR  = 2'd1,
    DBL   = 2'd2
  } status_t;

  // A non-zero syndrome names the 1-based position of the flipped bit.
  function automatic logic [2:0] syn_to_idx(input logic [2:0] syn);
    return syn - 3'd1;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D3_IDX], code[D2_IDX], code[D1_IDX], code[D0_IDX]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome {s2,s1,s0} and overall parity of an extended Hamming(8,4) codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [2:0]        syn_o,
  output logic              par_o
);

  assign syn_o[0] = code_i[P1_IDX] ^ code_i[D0_IDX] ^ code_i[D1_IDX] ^ code_i[D3_IDX];
  assign syn_o[1] = code_i[P2_IDX] ^ code_i[D0_IDX] ^ code_i[D2_IDX] ^ code_i[D3_IDX];
  assign syn_o[2] = code_i[P3_IDX] ^ code_i[D1_IDX] ^ code_i[D2_IDX] ^ code_i[D3_IDX];
  assign par_o    = (^code_i[P4_IDX-1:0]) ^ code_i[P4_IDX];

endmodule

// File: rtl/hamming_decoder.sv
// SECDED Hamming(8,4) decoder: 2-cycle latency, 1 word/cycle, valid/ready with full backpressure.
// Define HAMMING_DEC_STATS_EN to enable the saturating corrected/double-error counters.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_dbl,
  output logic [2:0]        syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_dbl
);

  logic              s1_vld_q,  s1_vld_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [2:0]        s1_syn_q,  s1_syn_d;
  logic              s1_par_q,  s1_par_d;

  logic              out_vld_q,  out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_corr_q, out_corr_d;
  logic              out_dbl_q,  out_dbl_d;
  logic [2:0]        out_syn_q,  out_syn_d;

  logic [2:0]        syn_c;
  logic              par_c;
  logic              s2_adv;
  status_t           status_c;
  logic [CODE_W-1:0] fixed_c;

  hamming_syndrome u_syndrome (
    .code_i (code_in),
    .syn_o  (syn_c),
    .par_o  (par_c)
  );

  assign s2_adv   = !out_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_adv;

  always_comb begin
    status_c = CLEAN;
    fixed_c  = s1_code_q;
    if (s1_syn_q != 3'd0) begin
      status_c = s1_par_q ? CORR : DBL;
    end else if (s1_par_q) begin
      status_c = CORR;
    end
    // A P4-only error has zero syndrome and leaves the data bits untouched.
    if (status_c == CORR && s1_syn_q != 3'd0) begin
      fixed_c = s1_code_q ^ (8'd1 << syn_to_idx(s1_syn_q));
    end
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_corr_d = out_corr_q;
    out_dbl_d  = out_dbl_q;
    out_syn_d  = out_syn_q;

    if (in_ready) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_code_d = code_in;
        s1_syn_d  = syn_c;
        s1_par_d  = par_c;
      end
    end

    if (s2_adv) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_data_d = extract_data(fixed_c);
        out_corr_d = (status_c == CORR);
        out_dbl_d  = (status_c == DBL);
        out_syn_d  = s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_vld_q   <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_corr_q <= 1'b0;
      out_dbl_q  <= 1'b0;
      out_syn_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_code_q  <= s1_code_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_corr_q <= out_corr_d;
      out_dbl_q  <= out_dbl_d;
      out_syn_q  <= out_syn_d;
    end
  end

  assign out_valid = out_vld_q;
  assign data_out  = out_data_q;
  assign err_corr  = out_corr_q;
  assign err_dbl   = out_dbl_q;
  assign syndrome  = out_syn_q;

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_dbl_q,  cnt_dbl_d;
  logic             out_hs;

  assign out_hs = out_vld_q && out_ready;

  // Clear has priority over a coinciding event, which is then not counted.
  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_dbl_d  = cnt_dbl_q;
    if (cnt_clr) begin
      cnt_corr_d = '0;
      cnt_dbl_d  = '0;
    end else if (out_hs) begin
      if (out_corr_q && cnt_corr_q != '1) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (out_dbl_q && cnt_dbl_q != '1)   cnt_dbl_d  = cnt_dbl_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_corr_q <= '0;
      cnt_dbl_q  <= '0;
    end else begin
      cnt_corr_q <= cnt_corr_d;
      cnt_dbl_q  <= cnt_dbl_d;
    end
  end

  assign cnt_corr = cnt_corr_q;
  assign cnt_dbl  = cnt_dbl_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_corr       = '0;
  assign cnt_dbl        = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder; counter expectations follow HAMMING_DEC_STATS_EN.
module tb_hamming_decoder;

  localparam int CNT_W = 2;
`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       code_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       data_out;
  logic             err_corr;
  logic             err_dbl;
  logic [2:0]       syndrome;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_dbl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_in   (code_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_corr  (err_corr),
    .err_dbl   (err_dbl),
    .syndrome  (syndrome),
    .cnt_clr   (cnt_clr),
    .cnt_corr  (cnt_corr),
    .cnt_dbl   (cnt_dbl)
  );

  task automatic test_reset();
    rstn = 1'b1; in_valid = 1'b1; code_in = 8'hFF; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 4'h0 || err_corr !== 1'b0 ||
        err_dbl !== 1'b0 || syndrome !== 3'd0 || cnt_corr !== '0 || cnt_dbl !== '0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b d=%h c=%b e=%b s=%0d cc=%0d cd=%0d, want rdy=1 rest 0",
               in_ready, out_valid, data_out, err_corr, err_dbl, syndrome, cnt_corr, cnt_dbl);
    end
  endtask

  task automatic test_clean();
    logic [7:0] codes [3];
    logic [3:0] exp_d [3];
    codes = '{8'h00, 8'h55, 8'hFF};
    exp_d = '{4'h0, 4'hB, 4'hF};
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = (n < 3);
      code_in  = (n < 3) ? codes[n] : 8'h00;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL clean_in_ready n=%0d: got %b want 1", n, in_ready);
      end
      checks++;
      if (n < 2) begin
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL clean_latency n=%0d: out_valid got %b want 0", n, out_valid);
        end
      end else if (out_valid !== 1'b1 || data_out !== exp_d[n-2] || err_corr !== 1'b0 ||
                   err_dbl !== 1'b0 || syndrome !== 3'd0) begin
        errors++;
        $display("FAIL clean_word%0d: got vld=%b d=%h c=%b e=%b s=%0d want vld=1 d=%h c=0 e=0 s=0",
                 n-2, out_valid, data_out, err_corr, err_dbl, syndrome, exp_d[n-2]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      in_valid = (n < 7);
      code_in  = 8'h55 ^ (8'h01 << n);
      #1;
      if (n >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 4'hB || err_corr !== 1'b1 ||
            err_dbl !== 1'b0 || syndrome !== 3'(n - 1)) begin
          errors++;
          $display("FAIL single_bit%0d: got vld=%b d=%h c=%b e=%b s=%0d want vld=1 d=b c=1 e=0 s=%0d",
                   n-2, out_valid, data_out, err_corr, err_dbl, syndrome, n-1);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_p4();
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; code_in = 8'hD5;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 4'hB || err_corr !== 1'b1 || err_dbl !== 1'b0 || syndrome !== 3'd0) begin
      errors++;
      $display("FAIL p4_error: got vld=%b d=%h c=%b e=%b s=%0d want vld=1 d=b c=1 e=0 s=0",
               out_valid, data_out, err_corr, err_dbl, syndrome);
    end
  endtask

  task automatic test_double();
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; code_in = 8'h41;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 4'h8 || err_corr !== 1'b0 || err_dbl !== 1'b1 || syndrome !== 3'd6) begin
      errors++;
      $display("FAIL double_error: got vld=%b d=%h c=%b e=%b s=%0d want vld=1 d=8 c=0 e=1 s=6",
               out_valid, data_out, err_corr, err_dbl, syndrome);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [6];
    logic [3:0] exp_d [6];
    int si, ri, first_drop;
    logic prev_stall;
    logic [3:0] sv_d;
    words = '{8'h87, 8'h99, 8'h1E, 8'hAA, 8'h4B, 8'hFF};
    exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hF};
    si = 0; ri = 0; first_drop = -1; prev_stall = 1'b0; sv_d = 4'h0;
    for (int cyc = 0; cyc < 40 && ri < 6; cyc++) begin
      @(negedge clk);
      in_valid  = (si < 6);
      code_in   = (si < 6) ? words[si] : 8'h00;
      out_ready = (cyc >= 5);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== sv_d) begin
          errors++; $display("FAIL bp_stable cyc=%0d: got vld=%b d=%h want vld=1 d=%h", cyc, out_valid, data_out, sv_d);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL bp_ready_comb: in_ready got %b want 1", in_ready);
        end
      end
      if (in_valid && !in_ready && first_drop < 0) first_drop = si;
      if (out_valid && out_ready) begin
        checks++;
        if (data_out !== exp_d[ri] || err_corr !== 1'b0 || err_dbl !== 1'b0) begin
          errors++; $display("FAIL bp_order word%0d: got d=%h c=%b e=%b want d=%h c=0 e=0", ri, data_out, err_corr, err_dbl, exp_d[ri]);
        end
        ri++;
      end
      prev_stall = out_valid && !out_ready;
      sv_d = data_out;
      if (in_valid && in_ready) si++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (ri != 6 || first_drop != 2) begin
      errors++; $display("FAIL bp_count: got outputs=%0d drop_after=%0d want outputs=6 drop_after=2", ri, first_drop);
    end
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_counters();
    logic [7:0] codes [5];
    logic [CNT_W-1:0] exp_c, exp_dbl;
    codes = '{8'h54, 8'h57, 8'h51, 8'h5D, 8'h45};
    @(negedge clk); rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    @(negedge clk); rstn = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      in_valid = (n < 5);
      code_in  = (n < 5) ? codes[n] : 8'h00;
      #1;
      if (n >= 2 && n < 7) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 4'hB || err_corr !== 1'b1) begin
          errors++; $display("FAIL cnt_word%0d: got vld=%b d=%h c=%b want vld=1 d=b c=1", n-2, out_valid, data_out, err_corr);
        end
      end
      exp_c = (STATS && n >= 3) ? ((n - 2 >= int'(CMAX)) ? CMAX : CNT_W'(n - 2)) : '0;
      checks++;
      if (cnt_corr !== exp_c || cnt_dbl !== '0) begin
        errors++; $display("FAIL cnt_sat n=%0d: got corr=%0d dbl=%0d want corr=%0d dbl=0", n, cnt_corr, cnt_dbl, exp_c);
      end
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      in_valid = (n < 3);
      code_in  = 8'h41;
      cnt_clr  = (n == 3);
      #1;
      if (n >= 2 && n < 5) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 4'h8 || err_dbl !== 1'b1 || err_corr !== 1'b0) begin
          errors++; $display("FAIL cnt_dbl_word n=%0d: got vld=%b d=%h e=%b c=%b want vld=1 d=8 e=1 c=0", n, out_valid, data_out, err_dbl, err_corr);
        end
      end
      exp_c   = (STATS && n <= 3) ? CMAX : '0;
      exp_dbl = (STATS && (n == 3 || n == 5)) ? CNT_W'(1) : '0;
      checks++;
      if (cnt_corr !== exp_c || cnt_dbl !== exp_dbl) begin
        errors++; $display("FAIL cnt_clr n=%0d: got corr=%0d dbl=%0d want corr=%0d dbl=%0d", n, cnt_corr, cnt_dbl, exp_c, exp_dbl);
      end
    end
    in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] codes [3];
    codes = '{8'h45, 8'h41, 8'hD5};
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); in_valid = 1'b1; code_in = codes[n];
    end
    @(negedge clk); in_valid = 1'b1; code_in = 8'hAA;
    #1;
    checks++;
    if (out_valid !== 1'b1 || err_dbl !== 1'b1 || cnt_corr !== (STATS ? CNT_W'(1) : '0)) begin
      errors++; $display("FAIL mid_pre: got vld=%b e=%b corr=%0d want vld=1 e=1 corr=%0d", out_valid, err_dbl, cnt_corr, STATS ? 1 : 0);
    end
    rstn = 1'b1;
    @(negedge clk); rstn = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 4'h0 || err_corr !== 1'b0 || err_dbl !== 1'b0 ||
        syndrome !== 3'd0 || cnt_corr !== '0 || cnt_dbl !== '0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b d=%h c=%b e=%b s=%0d cc=%0d cd=%0d want all 0",
               out_valid, data_out, err_corr, err_dbl, syndrome, cnt_corr, cnt_dbl);
    end
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL mid_flush: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
    end
  endtask

  initial begin
    rstn = 1'b1; in_valid = 1'b0; code_in = 8'h00; out_ready = 1'b0; cnt_clr = 1'b0;
    test_reset();
    test_clean();
    test_single();
    test_p4();
    test_double();
    test_backpressure();
    test_counters();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
- SECDED decoder for the 8-bit extended Hamming(8,4) codeword produced by the upstream Hamming encoder. It recovers the 4-bit data word.
- Corrects any single-bit error, including an error in the overall-parity bit, and flags double-bit errors as uncorrectable.
- Two-stage pipeline with valid/ready handshakes on both sides. Optional saturating error-statistics counters.

Parameters:
- CNT_W, default 16: width of each error-statistics counter.

Ports:
- clk  in  1: single clock, rising edge.
- rstn  in  1: reset; synchronous, active-high (1 = reset).
- in_valid  in  1: code_in holds a valid codeword.
- in_ready  out  1: decoder can accept a codeword this cycle.
- code_in  in  8: codeword. Bit map: [0]=P1, [1]=P2, [2]=D0, [3]=P3, [4]=D1, [5]=D2, [6]=D3, [7]=P4 (overall parity).
- out_valid  out  1: result outputs are valid.
- out_ready  in  1: consumer accepts the result this cycle.
- data_out  out  4: decoded data {D3,D2,D1,D0}.
- err_corr  out  1: a single-bit error was detected and corrected.
- err_dbl  out  1: double-bit error; data_out is uncorrected.
- syndrome  out  3: raw syndrome {s2,s1,s0}.
- cnt_clr  in  1: synchronous clear of both counters.
- cnt_corr  out  CNT_W: count of corrected words.
- cnt_dbl  out  CNT_W: count of uncorrectable words.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all valid flags, data_out, err_corr, err_dbl, syndrome and both counters are 0. in_ready is 1 in the first cycle after reset deasserts.
- A reset asserted mid-stream discards all in-flight words. No partial output appears afterwards.
- Syndrome bits:
  - s0 = c0^c2^c4^c6
  - s1 = c1^c2^c5^c6
  - s2 = c3^c4^c5^c6
  - p = XOR of c0..c7
- Stage 1 registers code_in, the syndrome and p on an input handshake (in_valid && in_ready).
- Stage 2 classifies the word and registers the result:
  - s==0, p==0: clean. data_out = {c6,c5,c4,c2}; both flags 0.
  - s!=0, p==1: single error at bit index s-1. That bit is flipped before data extraction; err_corr=1.
  - s==0, p==1: error in P4 only. Data is taken as-is; err_corr=1.
  - s!=0, p==0: double error. data_out = raw {c6,c5,c4,c2}; err_dbl=1, err_corr=0.
- Latency: 2 cycles from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Handshake rules:
  - Each stage advances when it is empty or its successor is advancing.
  - in_ready = !s1_valid || s1_advance. in_ready is combinational from out_ready.
  - The output holds stable while out_valid && !out_ready.
  - No word is dropped or duplicated under any backpressure pattern.
  - Input handshake and output handshake in the same cycle are both honoured.

Optional Feature:
- Macro: HAMMING_DEC_STATS_EN.
- With the macro defined:
  - cnt_corr increments on each output handshake with err_corr=1.
  - cnt_dbl increments on each output handshake with err_dbl=1.
  - Both counters saturate at all-ones.
  - cnt_clr clears both counters. If clear and an increment coincide, the clear wins and that event is not counted.
- Without the macro: both counters are tied to 0 and cnt_clr is ignored. The port list is unchanged.

Decomposition:
- Package hamming_pkg holds:
  - CODE_W=8 and DATA_W=4.
  - Bit-index constants for P1..P4 and D0..D3.
  - A status enum {CLEAN, CORR, DBL}.
  - A syndrome-to-bit-index function.
  - The package is shared with the encoder.
- Sub-module hamming_syndrome: combinational, code_in -> {syndrome, p}, instantiated in stage 1.

Test Plan:
- Clean words: stream 0x00, 0x55, 0xFF with out_ready=1 -> data_out 0x0, 0xB, 0xF, arriving 2 cycles after each accept; both flags 0 throughout.
- Single data-bit error: 0x45 (0x55 with bit 4 flipped) -> syndrome=5, err_corr=1, data_out=0xB. Repeat the single flip on each bit index 0..6 of 0x55 -> data_out=0xB and err_corr=1 every time.
- P4 error: 0xD5 -> syndrome=0, err_corr=1, data_out=0xB.
- Double error: 0x41 (bits 2 and 4 flipped) -> syndrome=6, err_dbl=1, err_corr=0, data_out=0x8 (uncorrected).
- Backpressure: 6-word stream with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; all 6 words emerge in order with no loss or duplication; outputs stable while stalled.
- Counters and reset (macro defined, CNT_W=2):
  - 5 corrected words -> cnt_corr=3 (saturated).
  - Assert cnt_clr together with a double-error handshake -> cnt_dbl=0.
  - Assert rstn mid-stream -> out_valid=0 the next cycle and counters=0.
